// File: rtl/demux1024_collector_pkg.sv
// rtl/demux1024_collector_pkg.sv - shared types, defaults and width helper for the mux/demux family
package demux1024_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int unsigned N_DEF     = 1024;
    localparam int unsigned SEL_W_DEF = 10;

    // Index width for an n-way mux or demux; never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux1024_collector_bit_writer.sv
// rtl/demux1024_collector_bit_writer.sv - one-hot index decode and per-bit word register
module demux_bit_writer
    import demux1024_collector_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   we_i,
    input  logic [width_of(N)-1:0] idx_i,
    input  logic                   bit_i,
    output logic [N-1:0]           word_o
);

    localparam int unsigned IDX_W = width_of(N);

    logic [N-1:0] en;
    logic [N-1:0] word_q;

    // Decode the write index into a one-hot enable, qualified by the write strobe.
    always_comb begin
        en = '0;
        for (int i = 0; i < N; i++) begin
            en[i] = we_i && (idx_i == IDX_W'(i));
        end
    end

    // Clear has priority; otherwise only the enabled position takes the new bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clr_i) begin
            word_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    word_q[i] <= bit_i;
                end
            end
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/demux1024_collector.sv
// rtl/demux1024_collector.sv - serial-bit to N-bit word collector with valid/ready handshake
module demux1024_collector
    import demux1024_collector_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             auto_inc,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [SEL_W:0]   beat_cnt
);

    localparam logic [SEL_W:0] LAST_BEAT = (SEL_W + 1)'(N - 1);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W:0]   beat_cnt_q;

    logic             accept;
    logic             clear;
    logic [SEL_W-1:0] idx;

    // A start in COLLECT wins over a coincident beat; start is ignored in HOLD.
    assign accept = (state_q == COLLECT) && in_valid && !start;
    assign clear  = start && (state_q != HOLD);
    assign idx    = auto_inc ? ptr_q : sel;

    // Frame FSM with the write pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= COLLECT;
                        ptr_q      <= '0;
                        beat_cnt_q <= '0;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        ptr_q      <= '0;
                        beat_cnt_q <= '0;
                    end else if (accept) begin
                        ptr_q      <= ptr_q + 1'b1;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    demux_bit_writer #(
        .N (N)
    ) u_writer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clear),
        .we_i   (accept),
        .idx_i  (idx),
        .bit_i  (in_bit),
        .word_o (out)
    );

    // Handshake outputs are pure decodes of the registered state.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_demux1024_collector.sv
// tb/tb_demux1024_collector.sv - self-checking bench for demux1024_collector
module tb_demux1024_collector;

    localparam int N     = 1024;
    localparam int SEL_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             auto_inc;
    logic [SEL_W-1:0] sel;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     out;
    logic             out_valid;
    logic             out_ack;
    logic [SEL_W:0]   beat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1024_collector #(
        .N     (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .auto_inc  (auto_inc),
        .sel       (sel),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .beat_cnt  (beat_cnt)
    );

    typedef struct {
        logic        st;
        logic        ai;
        logic [9:0]  sl;
        logic        b;
        logic        v;
        logic        ack;
        logic        rdy;
        logic        ov;
        logic [10:0] cnt;
        logic [15:0] low;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N; i++) begin
                if (act[i] !== exp[i]) begin
                    $display("FAIL %s: out[%0d] got %b expected %b", name, i, act[i], exp[i]);
                    break;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic [SEL_W-1:0] s, input logic b);
        auto_inc = a;
        sel      = s;
        in_bit   = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        cyc();
        out_ack = 1'b0;
    endtask

    logic [N-1:0] exp_w;
    int           p;
    int           acc;
    int           budget;
    logic         hold_ok;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        auto_inc = 1'b1;
        sel      = '0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;

        //                st ai sel     b  v  ack rdy ov cnt     low
        tbl[0] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd1, 16'h0001};
        tbl[3] = '{1'b0, 1'b1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2, 16'h0001};
        tbl[4] = '{1'b0, 1'b0, 10'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd3, 16'h0021};
        tbl[5] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd3, 16'h0021};
        tbl[6] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd4, 16'h0029};
        tbl[7] = '{1'b0, 1'b0, 10'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd5, 16'h0009};
        tbl[8] = '{1'b1, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 16'h0000};
        tbl[9] = '{1'b0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd1, 16'h0001};

        cyc();
        cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk_word("rst_out", out, '0);
        rst_n = 1'b1;
        cyc();

        // Table of single-cycle steps starting from IDLE.
        for (int k = 0; k < 10; k++) begin
            start    = tbl[k].st;
            auto_inc = tbl[k].ai;
            sel      = tbl[k].sl;
            in_bit   = tbl[k].b;
            in_valid = tbl[k].v;
            out_ack  = tbl[k].ack;
            cyc();
            chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
            chk($sformatf("tbl%0d_beat_cnt", k), beat_cnt, tbl[k].cnt);
            chk($sformatf("tbl%0d_out_low", k), out[15:0], tbl[k].low);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset mid-frame: after 5 beats, no clock edge needed.
        do_start();
        for (int i = 0; i < 5; i++) beat(1'b1, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_word("async_rst_out", out, '0);
        chk("async_rst_beat_cnt", beat_cnt, 0);
        chk("async_rst_in_ready", in_ready, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Auto-increment frame with alternating bits.
        do_start();
        for (int i = 0; i < N; i++) begin
            exp_w[i] = i[0];
            beat(1'b1, '0, i[0]);
            if (i == N - 2) begin
                chk("auto_ov_before_last", out_valid, 0);
                chk("auto_cnt_before_last", beat_cnt, N - 1);
            end
        end
        chk("auto_out_valid", out_valid, 1);
        chk("auto_in_ready", in_ready, 0);
        chk("auto_beat_cnt", beat_cnt, N);
        chk_word("auto_out", out, exp_w);
        do_ack();
        chk("auto_ack_out_valid", out_valid, 0);
        chk("auto_ack_beat_cnt", beat_cnt, N);
        chk_word("auto_ack_out_kept", out, exp_w);

        // Addressed frame: only bit 1023 ends up set.
        do_start();
        for (int i = 0; i < N; i++) beat(1'b0, SEL_W'(N - 1 - i), (i == 0));
        exp_w = '0;
        exp_w[N-1] = 1'b1;
        chk("addr_out_valid", out_valid, 1);
        chk_word("addr_out", out, exp_w);
        do_ack();

        // Duplicate writes to index 7, then one auto beat lands at ptr=1023.
        do_start();
        for (int i = 0; i < N - 1; i++) beat(1'b0, SEL_W'(7), 1'b1);
        chk("mixed_ov_early", out_valid, 0);
        beat(1'b1, '0, 1'b1);
        exp_w = '0;
        exp_w[7] = 1'b1;
        exp_w[N-1] = 1'b1;
        chk("mixed_out_valid", out_valid, 1);
        chk_word("mixed_out", out, exp_w);
        do_ack();

        // Backpressure: random in_valid, then delayed ack while beats are offered in HOLD.
        do_start();
        exp_w  = '0;
        p      = 0;
        acc    = 0;
        budget = 0;
        auto_inc = 1'b1;
        while (acc < N && budget < 5000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            if (in_valid) begin
                exp_w[p] = in_bit;
                p   = (p + 1) % N;
                acc++;
            end
            cyc();
            budget++;
        end
        in_valid = 1'b0;
        chk("bp_no_timeout", (acc == N), 1);
        chk("bp_out_valid", out_valid, 1);
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            auto_inc = 1'b0;
            sel      = SEL_W'(i);
            in_bit   = ~exp_w[i];
            in_valid = 1'b1;
            cyc();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== exp_w || beat_cnt !== 11'(N))
                hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_hold_stable", hold_ok, 1);
        chk_word("bp_out", out, exp_w);
        do_ack();
        chk("bp_ack_idle", out_valid, 0);

        // start colliding with a beat at beat_cnt=500 drops the beat and restarts.
        do_start();
        for (int i = 0; i < 500; i++) beat(1'b1, '0, 1'b1);
        chk("coll_cnt_500", beat_cnt, 500);
        start = 1'b1;
        beat(1'b1, '0, 1'b1);
        start = 1'b0;
        chk("coll_cnt_cleared", beat_cnt, 0);
        chk_word("coll_out_cleared", out, '0);
        for (int i = 0; i < N; i++) beat(1'b1, '0, 1'b0);
        chk("coll_out_valid", out_valid, 1);
        // start with out_ack in HOLD goes to IDLE, not a new frame.
        start   = 1'b1;
        out_ack = 1'b1;
        cyc();
        start   = 1'b0;
        out_ack = 1'b0;
        chk("startack_out_valid", out_valid, 0);
        chk("startack_in_ready", in_ready, 0);
        chk("startack_beat_cnt", beat_cnt, N);
        beat(1'b1, '0, 1'b1);
        chk("idle_ignores_beat_cnt", beat_cnt, N);
        chk("idle_ignores_in_ready", in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
